// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one single-port memory.
// Data side wins by default; a starvation counter forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // owner: 0 = IF, 1 = data side
  typedef struct packed {
    logic              owner;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state, state_nxt;
  req_t       cap;
  logic [3:0] cnt, starve;
  logic       gnt_d_c, gnt_if_c;

  always_comb begin
    state_nxt = state;
    gnt_d_c   = 1'b0;
    gnt_if_c  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && starve == SMAX)) gnt_d_c  = 1'b1;
        else if (if_req)                          gnt_if_c = 1'b1;
        if (gnt_d_c || gnt_if_c) state_nxt = WAIT;
      end
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are combinational, so gate them to keep every output low during reset.
  assign if_gnt    = gnt_if_c & ~reset;
  assign d_gnt     = gnt_d_c & ~reset;
  assign mem_en    = (state == WAIT);
  assign mem_wen   = mem_en & cap.wen;
  assign mem_addr  = cap.addr;
  assign mem_wdata = cap.wdata;
  assign if_rvalid = (state == RESP) & ~cap.owner;
  assign d_rvalid  = (state == RESP) & cap.owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      cap      <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nxt;

      if (gnt_d_c && if_req)         starve <= (starve == SMAX) ? SMAX : starve + 4'd1;
      else if (gnt_if_c || !if_req)  starve <= '0;

      case (state)
        IDLE: if (gnt_d_c || gnt_if_c) begin
          cap.owner <= gnt_d_c;
          cap.wen   <= gnt_d_c & d_wen;
          cap.addr  <= gnt_d_c ? d_addr : if_addr;
          cap.wdata <= gnt_d_c ? d_wdata : '0;
          cnt       <= LAT_M1;
        end
        WAIT: begin
          if (cnt != 4'd0)    cnt      <= cnt - 4'd1;
          else if (cap.owner) d_rdata  <= cap.wen ? '0 : mem_rdata;
          else                if_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter: a timeline-level reference model
// predicts grants, memory windows and responses; a separate monitor scores the responses.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0, reset;
  logic        if_req, d_req, d_wen;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_wen;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0, nerr = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Memory device: data only valid in the MEM_LAT-th enabled cycle, write commits then too.
  logic [31:0] mem [256];
  bit          mem_w [256];
  int          en_cnt = 0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen && en_cnt == LAT - 1) begin
        mem[mem_addr[9:2]]   <= mem_wdata;
        mem_w[mem_addr[9:2]] <= 1'b1;
      end
      en_cnt <= en_cnt + 1;
    end else en_cnt <= 0;
  end
  function automatic logic [31:0] dev_read(input int i);
    return mem_w[i] ? mem[i] : init_val(i);
  endfunction
  assign mem_rdata = (mem_en && en_cnt == LAT - 1) ? dev_read(int'(mem_addr[9:2])) : 32'hBAD0BAD0;

  // Reference model: one access occupies LAT+2 cycles starting at its grant.
  typedef struct { bit d; logic [31:0] data; int due; } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [256];
  bit          ref_w [256];
  int          free_at = 0, st = 0, en_from = 0, en_to = -1;
  logic [31:0] e_addr, e_wd;
  bit          e_wen;
  bit          pend_v = 0;
  int          pend_due, pend_idx;
  logic [31:0] pend_data;
  bit          rec = 0;
  byte         gseq[$];

  always @(negedge clk) begin : model
    bit gi, gd;
    int idx;
    logic [31:0] rd;
    gi = 0; gd = 0;
    if (reset) begin
      q.delete(); pend_v = 0; st = 0; free_at = 0; en_from = 0; en_to = -1;
    end else begin
      if (pend_v && cyc >= pend_due) begin
        ref_mem[pend_idx] = pend_data; ref_w[pend_idx] = 1; pend_v = 0;
      end
      if (cyc >= free_at) begin
        if (d_req && !(if_req && st == SMAX)) gd = 1;
        else if (if_req)                      gi = 1;
      end
      if (gd && if_req)         st = (st < SMAX) ? st + 1 : SMAX;
      else if (gi || !if_req)   st = 0;
      chk("if_gnt", if_gnt, gi);
      chk("d_gnt", d_gnt, gd);
      chk("mem_en", mem_en, (cyc >= en_from && cyc <= en_to));
      if (cyc >= en_from && cyc <= en_to) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wen", mem_wen, e_wen);
        if (e_wen) chk("mem_wdata", mem_wdata, e_wd);
      end
      if (gi || gd) begin
        e_addr  = gd ? d_addr : if_addr;
        e_wen   = gd & d_wen;
        e_wd    = d_wdata;
        en_from = cyc + 1;
        en_to   = cyc + LAT;
        free_at = cyc + LAT + 2;
        idx     = int'(e_addr[9:2]);
        rd      = ref_w[idx] ? ref_mem[idx] : init_val(idx);
        q.push_back('{d: gd, data: e_wen ? 32'h0 : rd, due: cyc + LAT + 1});
        if (e_wen) begin
          pend_v = 1; pend_due = cyc + LAT + 1; pend_idx = idx; pend_data = e_wd;
        end
        if (rec) gseq.push_back(gd ? 8'd68 : 8'd73);
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (if_rvalid && d_rvalid) chk("rvalid_overlap", 1, 0);
      if (if_rvalid || d_rvalid) begin
        if (q.size() == 0) chk("unexpected_rvalid", {if_rvalid, d_rvalid}, 0);
        else begin
          e = q.pop_front();
          chk("resp_owner_is_d", d_rvalid, e.d);
          chk("resp_cycle", cyc, e.due);
          chk("resp_data", e.d ? d_rdata : if_rdata, e.data);
        end
      end else if (q.size() != 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("rvalid_timeout", 0, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit d, output int t);
    bit ok;
    ok = 0; t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d ? d_gnt : if_gnt) begin ok = 1; t = cyc; break; end
    end
    chk("gnt_wait", ok, 1);
    tick();
  endtask

  task automatic single(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    int t;
    if (d) begin d_req = 1; d_wen = w; d_addr = a; d_wdata = wd; end
    else   begin if_req = 1; if_addr = a; end
    wait_gnt(d, t);
    d_req = 0; if_req = 0;
    repeat (LAT + 3) tick();
  endtask

  task automatic check_outputs_zero();
    chk("rst_if_gnt", if_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
  endtask

  initial begin
    int t1, t2;
    bit gi_s, gd_s;
    reset = 1; if_req = 1; d_req = 1; d_wen = 1;
    if_addr = 32'h100; d_addr = 32'h200; d_wdata = 32'h1;
    repeat (3) @(negedge clk);
    check_outputs_zero();
    tick();
    if_req = 0; d_req = 0; d_wen = 0;
    reset = 0;

    repeat (10) tick();                                  // idle: model expects no activity

    single(1, 1, 32'h100, 32'h00500093);                 // preload the instruction word
    single(0, 0, 32'h100, 32'h0);                        // IF read returns 0x00500093
    single(1, 1, 32'h200, 32'hDEADBEEF);                 // store, d_rdata = 0
    single(1, 0, 32'h200, 32'h0);                        // load back DEADBEEF

    // Back-to-back loads
    d_req = 1; d_wen = 0; d_addr = 32'h10;
    wait_gnt(1, t1);
    d_addr = 32'h14;
    wait_gnt(1, t2);
    d_req = 0;
    chk("b2b_gap", t2 - t1, LAT + 2);
    repeat (LAT + 3) tick();

    // Contention: both held continuously, fresh payload after each grant
    rec = 1; if_req = 1; d_req = 1; d_wen = 0;
    if_addr = {22'h0, 8'($urandom_range(255)), 2'b00};
    d_addr  = {22'h0, 8'($urandom_range(255)), 2'b00};
    repeat (10 * (LAT + 2) + 2) begin
      @(negedge clk); gi_s = if_gnt; gd_s = d_gnt;
      tick();
      if (gi_s) if_addr = {22'h0, 8'($urandom_range(255)), 2'b00};
      if (gd_s) begin
        d_addr = {22'h0, 8'($urandom_range(255)), 2'b00}; d_wen = 1'($urandom); d_wdata = $urandom;
      end
    end
    if_req = 0; d_req = 0; rec = 0;
    chk("contention_len_ge10", gseq.size() >= 10, 1);
    for (int i = 0; i < 10 && i < gseq.size(); i++)
      chk("contention_seq", gseq[i], (i % (SMAX + 1) == SMAX) ? 8'd73 : 8'd68);
    repeat (LAT + 3) tick();

    // Random traffic
    repeat (500) begin
      @(negedge clk); gi_s = if_gnt; gd_s = d_gnt;
      tick();
      if (gi_s || !if_req) begin
        if_req = ($urandom_range(99) < 60);
        if_addr = {22'h0, 8'($urandom_range(255)), 2'b00};
      end
      if (gd_s || !d_req) begin
        d_req = ($urandom_range(99) < 60); d_wen = 1'($urandom);
        d_addr = {22'h0, 8'($urandom_range(255)), 2'b00}; d_wdata = $urandom;
      end
    end
    if_req = 0; d_req = 0;
    repeat (LAT + 4) tick();

    // Reset in the middle of a store to 0x40
    t1 = int'(dev_read(16));
    d_req = 1; d_wen = 1; d_addr = 32'h40; d_wdata = 32'hCAFE0040;
    wait_gnt(1, t2);
    d_req = 0; d_wen = 0;
    chk("rst_midop_in_wait", mem_en, 1);
    #1 reset = 1;
    #1 check_outputs_zero();
    tick(); tick();
    reset = 0;
    repeat (20) tick();                                  // monitor flags any stray rvalid
    chk("rst_store_abandoned", dev_read(16), 32'(t1));
    single(1, 0, 32'h40, 32'h0);                         // fresh grant from IDLE, old data
    repeat (LAT + 4) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the pipelined RV32I CPU.
- Arbitrates requests and sequences each fixed-latency access with an FSM.
- Returns read data or write completion to the winning requester.
- Data side has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en assertion to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before IF is forced; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle grant pulse to IF
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched word
d_req  in  1  data request; held with d_wen/d_addr/d_wdata until d_gnt
d_wen  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle grant pulse to data side
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access enable
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. cnt, starve, owner, captured address/data, if_rdata and d_rdata all cleared to 0. Every output is 0. Any in-flight access is abandoned: no rvalid is issued and no write is completed afterwards.
- FSM states: IDLE, WAIT, RESP.
- IDLE: gnt is combinational.
  - Data wins if d_req and not (if_req and starve==STARVE_MAX).
  - Otherwise IF wins if if_req.
  - Otherwise no grant and the FSM stays in IDLE.
  - On a grant: capture owner, addr, wen (IF always 0) and wdata; load cnt=MEM_LAT-1; go to WAIT.
- WAIT:
  - mem_en=1; mem_addr, mem_wen and mem_wdata are driven from the captured registers and held stable throughout.
  - If cnt!=0: decrement cnt.
  - If cnt==0: register mem_rdata (or 0 for a store) into the owner's rdata; go to RESP.
- RESP: owner's rvalid=1 for exactly one cycle with rdata valid; mem_en=0; go to IDLE. rdata holds its value until the next response for that owner.
- Latency: gnt in cycle T; mem_en high T+1..T+MEM_LAT; rvalid in T+MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles. No new grant is issued in WAIT or RESP.
- Starvation counter:
  - On a data grant while if_req=1: starve increments, saturating at STARVE_MAX.
  - On an IF grant, or in any cycle with if_req=0: starve clears to 0.
- Simultaneous if_req and d_req with starve<STARVE_MAX: data wins.
- Requester protocol:
  - A requester holds req and its payload stable until gnt.
  - req still high in the cycle after gnt is a new request, evaluated in the next IDLE.
  - Payload changes before gnt are undefined behaviour; the arbiter latches payload only at grant.
- Grant pulses and rvalid pulses never overlap for the same requester. At most one gnt and at most one rvalid are asserted per cycle.

Test Plan:
- Reset mid-operation: assert reset during WAIT of a store to 0x40 → all outputs 0 immediately, no d_rvalid ever appears, next grant starts from IDLE.
- IF read, MEM_LAT=2: if_req=1, if_addr=0x100, mem_rdata=0x00500093 → if_gnt at T; mem_en=1 at T+1..T+2 with mem_addr=0x100; if_rvalid=1 with if_rdata=0x00500093 at T+3.
- Data store: d_req=1, d_wen=1, d_addr=0x200, d_wdata=0xDEADBEEF → mem_wen=1 for 2 cycles, d_rvalid pulse at T+3, d_rdata=0, if_rvalid stays 0.
- Contention: if_req and d_req both held high continuously, STARVE_MAX=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF, with grants every 4 cycles.
- Back-to-back data loads to 0x10 then 0x14 → second d_gnt exactly 4 cycles after the first; rdata values returned in order.
- Idle: no requests for 10 cycles → mem_en, gnt and rvalid all stay 0, starve stays 0.
